uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer and transmit sequencer that sits directly upstream of the `uart` wrapper's transmit side. It accepts bursts of bytes from system logic through a simple write-enable port and stores them in a circular FIFO. It then drains the FIFO one byte at a time into the UART, pulsing `send_data` with `tx_data` and waiting for `tx_done` before issuing the next byte. Producers can therefore write whole messages at clock rate without tracking UART bit timing.

## Interface
- `DEPTH`, 16: FIFO capacity in bytes; must be a power of two, ≥2.
- `AW`, `$clog2(DEPTH)`: pointer width (derived, not overridden).

Ports:
- `clk`  in  1: system clock, same clock as `uart`.
- `rst_n`  in  1: asynchronous active-low reset.
- `wr_en`  in  1: write strobe; one byte accepted per cycle when not full.
- `wr_data`  in  8: byte to enqueue.
- `full`  out  1: FIFO holds DEPTH bytes.
- `empty`  out  1: FIFO holds 0 bytes.
- `count`  out  AW+1: bytes currently stored, 0..DEPTH.
- `overflow`  out  1: one-cycle pulse when a write is dropped because the FIFO is full.
- `busy`  out  1: high while a byte is in flight to the UART (state WAIT).
- `send_data`  out  1: one-cycle start pulse to `uart.send_data`.
- `tx_data`  out  8: byte to `uart.tx_data`; stable from the `send_data` cycle until `tx_done`.
- `tx_done`  in  1: one-cycle pulse from `uart` when the stop bit completes.

## Operation
- Storage: DEPTH×8 register array, write pointer `wp` and read pointer `rp` (AW bits each, wrap modulo DEPTH), plus an occupancy counter `count`.
- Write: `wr_en && !full` stores `wr_data` at `wp` and increments `wp`. A write while full is dropped: no state change, `overflow` pulses next cycle.
- Full is evaluated on the registered `count`. A write in the same cycle as a pop while full is still dropped. There is no same-cycle bypass.
- Pop: occurs only on FSM issue. `tx_data <= mem[rp]`, `rp++`.
- `count` update: +1 on accepted write only, −1 on pop only, unchanged when both occur.
- FSM states:
  - IDLE: if `count != 0`, pop, assert `send_data` for one cycle, go to WAIT.
  - WAIT: `busy`=1. On `tx_done`: if `count != 0`, pop and pulse `send_data` on the next cycle, staying in WAIT (back-to-back issue). Otherwise go to IDLE.
- `tx_done` received in IDLE is ignored.
- `send_data` never asserts while a previous byte is unacknowledged.
- Bytes leave in exactly the write order. There is no reordering or loss except dropped overflow writes.

## Timing
- Reset values (asynchronous):
  - State IDLE; `wp`=`rp`=0; `count`=0.
  - `empty`=1, `full`=0, `overflow`=0, `busy`=0, `send_data`=0, `tx_data`=8'h00.
  - Memory contents are not reset.
- `empty`, `full` and `count` are registered and update the cycle after the causing edge.
- Latency from idle:
  - A byte written with `wr_en` high in cycle N sets `count`=1 from cycle N+1.
  - `send_data` is high in cycle N+2, with `tx_data` valid in that same cycle.
- Back-to-back: `tx_done` high in cycle M means the next `send_data` is high in cycle M+1 if `count != 0` in cycle M.
- `overflow` is a registered pulse, high in cycle N+1 for a dropped write in cycle N.
- Reset mid-transfer: all bytes are discarded and the FSM returns to IDLE immediately. `uart` shares `rst_n`, so no stale `tx_done` is expected. Any `tx_done` arriving in IDLE is ignored regardless.
- Pointer wrap: at `wp`/`rp` = DEPTH−1, the pointer increments to 0. `full`/`empty` are derived from `count` only, never from pointer equality.

## Test plan
- **Single byte:** reset, write 8'hA5 in cycle 10 → `send_data` high in cycle 12 only, `tx_data`=8'hA5 held. Drive `tx_done` in cycle 40 → `busy` low in cycle 41, `empty`=1.
- **Burst order:** write 8'h01..8'h05 on consecutive cycles, with a UART model returning `tx_done` 20 cycles after each `send_data` → UART receives 01,02,03,04,05 in order. Each `send_data` follows its preceding `tx_done` by exactly 1 cycle. `count` ends at 0.
- **Full/overflow (DEPTH=16):** hold `tx_done` low after the first issue and write 18 bytes → the first byte is in flight and 16 are buffered, so `full`=1 and `count`=16. Exactly one `overflow` pulse (the 18th byte). Draining delivers bytes 1..17.
- **Wrap-around:** 3 rounds of writing 10 bytes and draining fully → all 30 bytes emerge in order across the pointer wrap. `count` returns to 0 each round.
- **Simultaneous write and pop:** with `count`=3 in WAIT, assert `wr_en` in the cycle of the pop after `tx_done` → `count` stays 3 and the order is preserved.
- **Reset mid-operation:** with 6 bytes queued and one in flight, pulse `rst_n` low for 1 cycle → all outputs return to reset values immediately. A subsequent `tx_done` pulse produces no `send_data`. A new write of 8'h3C is sent normally.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte buffer and transmit sequencer for the transmit side of the uart
// wrapper. Producers push bytes at clock rate through wr_en/wr_data. The
// bytes are held in a circular FIFO and handed to the UART one at a time.
// Each byte gets a single-cycle send_data pulse, and the next byte is not
// issued until tx_done returns for the current one.
//
// Parameters
//   DEPTH      FIFO capacity in bytes (power of two, >= 2)
//   AW         pointer width, derived from DEPTH
//
// Ports
//   clk        system clock (shared with the uart)
//   rst_n      asynchronous active-low reset
//   wr_en      write strobe, one byte per cycle when not full
//   wr_data    byte to enqueue
//   full       FIFO holds DEPTH bytes
//   empty      FIFO holds no bytes
//   count      bytes currently stored (0..DEPTH)
//   overflow   one-cycle pulse, cycle after a write dropped while full
//   busy       a byte is in flight to the uart (waiting for tx_done)
//   send_data  one-cycle start pulse to uart.send_data
//   tx_data    byte to uart.tx_data, held from send_data until tx_done
//   tx_done    one-cycle completion pulse from the uart
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          busy,
  output logic          send_data,
  output logic [7:0]    tx_data,
  input  logic          tx_done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  // Storage, no reset on the array so it maps onto distributed/block RAM.
  logic [7:0]    mem [DEPTH];

  logic [0:0]    state_reg;
  logic [0:0]    state_next;
  logic [AW-1:0] wp_reg;
  logic [AW-1:0] rp_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          overflow_reg;
  logic          send_data_reg;
  logic [7:0]    tx_data_reg;

  logic          full_int;
  logic          empty_int;
  logic          wr_accept;
  logic          pop;

  // Status comes from the registered occupancy only; pointer equality is
  // ambiguous between full and empty and is never used.
  assign full_int  = (count_reg == FULL_COUNT);
  assign empty_int = (count_reg == '0);

  // A write while full is dropped even if a pop happens in the same cycle:
  // there is deliberately no same-cycle bypass.
  assign wr_accept = wr_en && !full_int;

  // Issue sequencer. A pop is the only way a byte leaves the FIFO, and it
  // always coincides with loading tx_data and launching send_data next cycle.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // tx_done in IDLE is meaningless and is ignored.
        if (!empty_int) begin
          pop        = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (!empty_int) begin
            // Back-to-back: issue immediately and stay in WAIT.
            pop = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Occupancy: a simultaneous accept and pop cancel out.
  always_comb begin
    count_next = count_reg;
    case ({wr_accept, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      wp_reg        <= '0;
      rp_reg        <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      send_data_reg <= 1'b0;
      tx_data_reg   <= 8'h00;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      overflow_reg  <= wr_en && full_int;
      send_data_reg <= pop;
      if (wr_accept) begin
        wp_reg <= wp_reg + PTR_ONE;
      end
      if (pop) begin
        rp_reg      <= rp_reg + PTR_ONE;
        // Registered read: tx_data then holds until the next pop, which
        // cannot happen before tx_done for this byte.
        tx_data_reg <= mem[rp_reg];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wp_reg] <= wr_data;
    end
  end

  assign full      = full_int;
  assign empty     = empty_int;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign busy      = (state_reg == ST_WAIT);
  assign send_data = send_data_reg;
  assign tx_data   = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo. A small UART model watches send_data on
// the falling edge, logs each issued byte, and (when auto_en is set) answers
// with tx_done 20 cycles after each send_data. Scenario tasks drive inputs
// just after the rising edge and check outputs at that point.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        tx_done;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
  logic        busy;
  logic        send_data;
  logic [7:0]  tx_data;

  logic        tx_done_man = 1'b0;
  logic        tx_done_auto = 1'b0;
  logic        auto_en = 1'b0;

  assign tx_done = tx_done_man | tx_done_auto;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int timer = 0;
  int ovf_cnt = 0;
  int proto_err = 0;
  bit outstanding = 1'b0;

  logic [7:0] rx_q[$];
  int         sd_cyc[$];
  int         done_cyc[$];

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .busy      (busy),
    .send_data (send_data),
    .tx_data   (tx_data),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART response driver: tx_done is driven just after the rising edge.
  always @(posedge clk) begin
    #1;
    tx_done_auto = 1'b0;
    if (timer > 0) begin
      timer--;
      if (timer == 0) tx_done_auto = 1'b1;
    end
  end

  // UART observer on the falling edge, one line per issued byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 1'b0;
      timer = 0;
    end else begin
      if (tx_done) begin
        done_cyc.push_back(cyc);
        outstanding = 1'b0;
      end
      if (send_data) begin
        if (outstanding) proto_err++;
        outstanding = 1'b1;
        rx_q.push_back(tx_data);
        sd_cyc.push_back(cyc);
        $display("cycle %0d: send_data byte %02h", cyc, tx_data);
        if (auto_en) timer = 20;
      end
      if (overflow) ovf_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rx_q.delete();
    sd_cyc.delete();
    done_cyc.delete();
    proto_err = 0;
  endtask

  // Bounded wait until n bytes were issued and the last one acknowledged.
  task automatic wait_drain(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (!(rx_q.size() >= n && !busy) && k < budget) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d bytes, expected %0d", tag, rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_cmp++;
    if ({empty, full, overflow, busy, send_data} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_flags: got %b, expected 10000", {empty, full, overflow, busy, send_data});
    end
    n_cmp++;
    if (count !== 5'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d, expected 0", count);
    end
    n_cmp++;
    if (tx_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_tx_data: got %02h, expected 00", tx_data);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single_byte();
    int n0;
    auto_en = 1'b0;
    clear_log();
    wr_en = 1'b1;
    wr_data = 8'hA5;
    n0 = cyc;
    tick(1);
    wr_en = 1'b0;
    n_cmp++;
    if (count !== 5'd1 || send_data !== 1'b0) begin
      n_err++;
      $display("FAIL single_n1: got count=%0d send=%b, expected count=1 send=0", count, send_data);
    end
    tick(1);
    n_cmp++;
    if (send_data !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_n2: got send=%b data=%02h busy=%b, expected 1 a5 1", send_data, tx_data, busy);
    end
    tick(1);
    n_cmp++;
    if (send_data !== 1'b0) begin
      n_err++;
      $display("FAIL single_pulse_width: got send=%b, expected 0", send_data);
    end
    tick(27);
    n_cmp++;
    if (tx_data !== 8'hA5 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_hold: got data=%02h busy=%b, expected a5 1", tx_data, busy);
    end
    tx_done_man = 1'b1;
    tick(1);
    tx_done_man = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: got busy=%b empty=%b, expected 0 1", busy, empty);
    end
    tick(2);
    n_cmp++;
    if (sd_cyc.size() != 1 || (sd_cyc.size() == 1 && sd_cyc[0] != n0 + 2)) begin
      n_err++;
      $display("FAIL single_send_cycle: got %0d sends, expected 1 at cycle %0d", sd_cyc.size(), n0 + 2);
    end
  endtask

  task automatic test_burst_order();
    auto_en = 1'b1;
    clear_log();
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick(1);
    end
    wr_en = 1'b0;
    wait_drain(5, 400, "burst");
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= rx_q.size() || rx_q[i] !== 8'(i + 1)) begin
        n_err++;
        $display("FAIL burst_byte%0d: got %02h, expected %02h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'(i + 1));
      end
    end
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (i >= sd_cyc.size() || i - 1 >= done_cyc.size() || sd_cyc[i] - done_cyc[i - 1] != 1) begin
        n_err++;
        $display("FAIL burst_gap%0d: got %0d, expected 1", i,
                 (i < sd_cyc.size() && i - 1 < done_cyc.size()) ? sd_cyc[i] - done_cyc[i - 1] : -1);
      end
    end
    n_cmp++;
    if (count !== 5'd0 || proto_err != 0) begin
      n_err++;
      $display("FAIL burst_end: got count=%0d proto_err=%0d, expected 0 0", count, proto_err);
    end
  endtask

  task automatic test_full_overflow();
    auto_en = 1'b0;
    clear_log();
    ovf_cnt = 0;
    for (int i = 1; i <= 18; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h40 + i);
      tick(1);
    end
    wr_en = 1'b0;
    n_cmp++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL full_state: got full=%b count=%0d ovf=%b, expected 1 16 1", full, count, overflow);
    end
    tick(1);
    n_cmp++;
    if (overflow !== 1'b0 || ovf_cnt != 1 || rx_q.size() != 1) begin
      n_err++;
      $display("FAIL full_ovf_once: got ovf=%b pulses=%0d sends=%0d, expected 0 1 1", overflow, ovf_cnt, rx_q.size());
    end
    auto_en = 1'b1;
    tx_done_man = 1'b1;
    tick(1);
    tx_done_man = 1'b0;
    wait_drain(17, 1000, "full_drain");
    for (int i = 0; i < 17; i++) begin
      n_cmp++;
      if (i >= rx_q.size() || rx_q[i] !== 8'(8'h41 + i)) begin
        n_err++;
        $display("FAIL full_byte%0d: got %02h, expected %02h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'(8'h41 + i));
      end
    end
    n_cmp++;
    if (count !== 5'd0 || ovf_cnt != 1 || proto_err != 0 || rx_q.size() != 17) begin
      n_err++;
      $display("FAIL full_end: got count=%0d pulses=%0d proto=%0d sends=%0d, expected 0 1 0 17",
               count, ovf_cnt, proto_err, rx_q.size());
    end
  endtask

  task automatic test_wrap_around();
    auto_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      clear_log();
      for (int i = 0; i < 10; i++) begin
        wr_en = 1'b1;
        wr_data = 8'(8'h90 + r * 10 + i);
        tick(1);
      end
      wr_en = 1'b0;
      wait_drain(10, 600, "wrap");
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (i >= rx_q.size() || rx_q[i] !== 8'(8'h90 + r * 10 + i)) begin
          n_err++;
          $display("FAIL wrap_r%0d_byte%0d: got %02h, expected %02h", r, i,
                   (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'(8'h90 + r * 10 + i));
        end
      end
      n_cmp++;
      if (count !== 5'd0 || empty !== 1'b1) begin
        n_err++;
        $display("FAIL wrap_r%0d_end: got count=%0d empty=%b, expected 0 1", r, count, empty);
      end
    end
  endtask

  task automatic test_simultaneous();
    auto_en = 1'b0;
    clear_log();
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'hC0 + i);
      tick(1);
    end
    wr_en = 1'b0;
    n_cmp++;
    if (count !== 5'd3 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL simul_pre: got count=%0d busy=%b, expected 3 1", count, busy);
    end
    tick(3);
    tx_done_man = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hC5;
    tick(1);
    tx_done_man = 1'b0;
    wr_en = 1'b0;
    auto_en = 1'b1;
    n_cmp++;
    if (count !== 5'd3 || send_data !== 1'b1 || tx_data !== 8'hC2) begin
      n_err++;
      $display("FAIL simul_post: got count=%0d send=%b data=%02h, expected 3 1 c2", count, send_data, tx_data);
    end
    wait_drain(5, 400, "simul");
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= rx_q.size() || rx_q[i] !== 8'(8'hC1 + i)) begin
        n_err++;
        $display("FAIL simul_byte%0d: got %02h, expected %02h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'(8'hC1 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    auto_en = 1'b0;
    clear_log();
    for (int i = 1; i <= 7; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'hD0 + i);
      tick(1);
    end
    wr_en = 1'b0;
    n_cmp++;
    if (count !== 5'd6 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: got count=%0d busy=%b, expected 6 1", count, busy);
    end
    tick(2);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({empty, full, overflow, busy, send_data} !== 5'b10000 || count !== 5'd0 || tx_data !== 8'h00) begin
      n_err++;
      $display("FAIL rstmid_async: got flags=%b count=%0d data=%02h, expected 10000 0 00",
               {empty, full, overflow, busy, send_data}, count, tx_data);
    end
    tick(1);
    rst_n = 1'b1;
    clear_log();
    tick(1);
    tx_done_man = 1'b1;
    tick(1);
    tx_done_man = 1'b0;
    tick(4);
    n_cmp++;
    if (rx_q.size() != 0 || busy !== 1'b0 || count !== 5'd0) begin
      n_err++;
      $display("FAIL rstmid_stale_done: got sends=%0d busy=%b count=%0d, expected 0 0 0", rx_q.size(), busy, count);
    end
    auto_en = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h3C;
    tick(1);
    wr_en = 1'b0;
    wait_drain(1, 100, "rstmid");
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C || count !== 5'd0) begin
      n_err++;
      $display("FAIL rstmid_new: got sends=%0d byte=%02h count=%0d, expected 1 3c 0",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, count);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst_order();
    test_full_overflow();
    test_wrap_around();
    test_simultaneous();
    test_reset_mid();
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
